axi_log_arbiter: RTL and testbench

Arbitrates AXI address-channel events from the read (AR) and write (AW) channels of one monitored port onto the single write port of the BRAM logger. Each channel has a small event FIFO. A round-robin arbiter feeds a registered output stage that connects directly to the logger's AXI-event inputs. Events that cannot be buffered are dropped and counted per channel, so software can judge trace completeness.

---
 rtl/axi_log_arbiter.sv | 167 ++++++++++++++++
 tb/tb_axi_log_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_log_arbiter.sv
// AXI AR/AW address-event arbiter feeding the BRAM logger write port.
// Per-channel event FIFOs, round-robin grant, registered output stage.
// Ports: Clk_CI/Rst_RI clock and async high reset; Ar*/Aw* observed
// address handshakes; Clear_SI flush; LogFull_SI logger full; Log*_DO
// registered event {channel,id}/addr/len with LogValid_SO; Ar/AwDropCnt_DO
// saturating counts of events lost to full FIFOs.
// Option: define AXI_LOG_ARB_AW_PRIO_EN for fixed AW-first priority.
module axi_log_arbiter #(
  parameter int unsigned AXI_ADDR_BITW = 32,
  parameter int unsigned AXI_ID_BITW   = 8,
  parameter int unsigned AXI_LEN_BITW  = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned DROP_CNT_BITW = 16
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RI,
  input  logic                     ArValid_SI,
  input  logic                     ArReady_SI,
  input  logic [AXI_ID_BITW-1:0]   ArId_DI,
  input  logic [AXI_ADDR_BITW-1:0] ArAddr_DI,
  input  logic [AXI_LEN_BITW-1:0]  ArLen_DI,
  input  logic                     AwValid_SI,
  input  logic                     AwReady_SI,
  input  logic [AXI_ID_BITW-1:0]   AwId_DI,
  input  logic [AXI_ADDR_BITW-1:0] AwAddr_DI,
  input  logic [AXI_LEN_BITW-1:0]  AwLen_DI,
  input  logic                     Clear_SI,
  input  logic                     LogFull_SI,
  output logic                     LogValid_SO,
  output logic [AXI_ID_BITW:0]     LogId_DO,
  output logic [AXI_ADDR_BITW-1:0] LogAddr_DO,
  output logic [AXI_LEN_BITW-1:0]  LogLen_DO,
  output logic [DROP_CNT_BITW-1:0] ArDropCnt_DO,
  output logic [DROP_CNT_BITW-1:0] AwDropCnt_DO
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = AXI_ID_BITW + AXI_ADDR_BITW + AXI_LEN_BITW;

  typedef logic [EW-1:0] entry_t;

  entry_t      ar_mem [FIFO_DEPTH];
  entry_t      aw_mem [FIFO_DEPTH];
  logic [PW:0] ar_wptr, ar_rptr;
  logic [PW:0] aw_wptr, aw_rptr;

  logic   ar_hs, aw_hs;
  logic   ar_empty, aw_empty;
  logic   ar_full, aw_full;
  logic   ar_push, aw_push;
  logic   ar_drop, aw_drop;
  logic   ar_pop, aw_pop;
  logic   consume, load, grant_aw;
  entry_t ar_head, aw_head, win_head;

  assign ar_hs = ArValid_SI && ArReady_SI;
  assign aw_hs = AwValid_SI && AwReady_SI;

  // Extra pointer bit: equal low bits with differing MSB means full.
  assign ar_empty = (ar_wptr == ar_rptr);
  assign aw_empty = (aw_wptr == aw_rptr);
  assign ar_full  = (ar_wptr[PW] != ar_rptr[PW]) &&
                    (ar_wptr[PW-1:0] == ar_rptr[PW-1:0]);
  assign aw_full  = (aw_wptr[PW] != aw_rptr[PW]) &&
                    (aw_wptr[PW-1:0] == aw_rptr[PW-1:0]);

  // Full is judged on current occupancy, so a same-cycle pop
  // does not rescue an event arriving at a full FIFO.
  assign ar_push = ar_hs && !ar_full && !Clear_SI;
  assign aw_push = aw_hs && !aw_full && !Clear_SI;
  assign ar_drop = ar_hs && ar_full && !Clear_SI;
  assign aw_drop = aw_hs && aw_full && !Clear_SI;

  assign consume = LogValid_SO && !LogFull_SI && !Clear_SI;
  assign load    = (!LogValid_SO || consume) &&
                   (!ar_empty || !aw_empty) && !Clear_SI;

`ifdef AXI_LOG_ARB_AW_PRIO_EN
  assign grant_aw = !aw_empty;
`else
  // High when AW had the most recent grant; resets to AW so AR
  // takes the first tie.
  logic last_aw;

  assign grant_aw = !aw_empty && (ar_empty || !last_aw);

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      last_aw <= 1'b1;
    end else if (Clear_SI) begin
      last_aw <= 1'b1;
    end else if (load) begin
      last_aw <= grant_aw;
    end
  end
`endif

  assign ar_pop   = load && !grant_aw;
  assign aw_pop   = load && grant_aw;
  assign ar_head  = ar_mem[ar_rptr[PW-1:0]];
  assign aw_head  = aw_mem[aw_rptr[PW-1:0]];
  assign win_head = grant_aw ? aw_head : ar_head;

  always_ff @(posedge Clk_CI) begin
    if (ar_push) begin
      ar_mem[ar_wptr[PW-1:0]] <= {ArId_DI, ArAddr_DI, ArLen_DI};
    end
    if (aw_push) begin
      aw_mem[aw_wptr[PW-1:0]] <= {AwId_DI, AwAddr_DI, AwLen_DI};
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      ar_wptr <= '0;
      ar_rptr <= '0;
      aw_wptr <= '0;
      aw_rptr <= '0;
    end else if (Clear_SI) begin
      ar_wptr <= '0;
      ar_rptr <= '0;
      aw_wptr <= '0;
      aw_rptr <= '0;
    end else begin
      if (ar_push) ar_wptr <= ar_wptr + 1'b1;
      if (ar_pop)  ar_rptr <= ar_rptr + 1'b1;
      if (aw_push) aw_wptr <= aw_wptr + 1'b1;
      if (aw_pop)  aw_rptr <= aw_rptr + 1'b1;
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      LogValid_SO <= 1'b0;
      LogId_DO    <= '0;
      LogAddr_DO  <= '0;
      LogLen_DO   <= '0;
    end else if (Clear_SI) begin
      LogValid_SO <= 1'b0;
      LogId_DO    <= '0;
      LogAddr_DO  <= '0;
      LogLen_DO   <= '0;
    end else if (load) begin
      LogValid_SO <= 1'b1;
      {LogId_DO[AXI_ID_BITW-1:0], LogAddr_DO, LogLen_DO} <= win_head;
      LogId_DO[AXI_ID_BITW] <= grant_aw;
    end else if (consume) begin
      LogValid_SO <= 1'b0;
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      ArDropCnt_DO <= '0;
      AwDropCnt_DO <= '0;
    end else if (Clear_SI) begin
      ArDropCnt_DO <= '0;
      AwDropCnt_DO <= '0;
    end else begin
      if (ar_drop && ArDropCnt_DO != '1)
        ArDropCnt_DO <= ArDropCnt_DO + 1'b1;
      if (aw_drop && AwDropCnt_DO != '1)
        AwDropCnt_DO <= AwDropCnt_DO + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_log_arbiter.sv
// Self-checking bench for axi_log_arbiter.
// Expected log entries are queued at stimulus time, popped on consume.
module tb_axi_log_arbiter;

  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ar_v, ar_r, aw_v, aw_r;
  logic [7:0]    ar_id, aw_id, ar_len, aw_len;
  logic [31:0]   ar_addr, aw_addr;
  logic          clr, full;
  logic          log_v;
  logic [8:0]    log_id;
  logic [31:0]   log_addr;
  logic [7:0]    log_len;
  logic [DW-1:0] ar_cnt, aw_cnt;

  logic [48:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  axi_log_arbiter #(.DROP_CNT_BITW(DW)) dut (
    .Clk_CI(clk), .Rst_RI(rst),
    .ArValid_SI(ar_v), .ArReady_SI(ar_r),
    .ArId_DI(ar_id), .ArAddr_DI(ar_addr), .ArLen_DI(ar_len),
    .AwValid_SI(aw_v), .AwReady_SI(aw_r),
    .AwId_DI(aw_id), .AwAddr_DI(aw_addr), .AwLen_DI(aw_len),
    .Clear_SI(clr), .LogFull_SI(full),
    .LogValid_SO(log_v), .LogId_DO(log_id),
    .LogAddr_DO(log_addr), .LogLen_DO(log_len),
    .ArDropCnt_DO(ar_cnt), .AwDropCnt_DO(aw_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  // Logger writes exactly in consume cycles; compare each write.
  always @(negedge clk) begin
    if (!rst && log_v && !full && !clr) begin
      if (exp_q.size() == 0) begin
        chk("extra_out", {63'd0, log_v}, 64'd0);
      end else begin
        chk("log", {15'd0, log_id, log_addr, log_len},
            {15'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ar_v = 0; ar_r = 0; aw_v = 0; aw_r = 0;
  endtask

  task automatic set_ar(input logic [7:0] id,
                        input logic [31:0] a,
                        input logic [7:0] l,
                        input bit push);
    ar_v = 1; ar_r = 1; ar_id = id; ar_addr = a; ar_len = l;
    if (push) exp_q.push_back({1'b0, id, a, l});
  endtask

  task automatic set_aw(input logic [7:0] id,
                        input logic [31:0] a,
                        input logic [7:0] l,
                        input bit push);
    aw_v = 1; aw_r = 1; aw_id = id; aw_addr = a; aw_len = l;
    if (push) exp_q.push_back({1'b1, id, a, l});
  endtask

  task automatic do_reset();
    idle();
    clr = 0; full = 0;
    exp_q.delete();
    rst = 1;
    step();
    step();
    rst = 0;
    step();
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (exp_q.size() != 0 && k < n) begin
      step();
      k++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    ar_id = 0; ar_addr = 0; ar_len = 0;
    aw_id = 0; aw_addr = 0; aw_len = 0;
    idle();
    clr = 0; full = 0;
    rst = 1;
    #1;
    chk("rst_valid", {63'd0, log_v}, 64'd0);
    chk("rst_id", {55'd0, log_id}, 64'd0);
    chk("rst_addr", {32'd0, log_addr}, 64'd0);
    chk("rst_len", {56'd0, log_len}, 64'd0);
    chk("rst_arcnt", 64'(ar_cnt), 64'd0);
    chk("rst_awcnt", 64'(aw_cnt), 64'd0);
    do_reset();

    // single AR event, exact latency
    set_ar(8'h05, 32'h1000, 8'd3, 1);
    step();
    idle();
    chk("lat_t1", {63'd0, log_v}, 64'd0);
    step();
    chk("lat_t2_v", {63'd0, log_v}, 64'd1);
    chk("lat_t2_id", {55'd0, log_id}, 64'h005);
    chk("lat_t2_addr", {32'd0, log_addr}, 64'h1000);
    chk("lat_t2_len", {56'd0, log_len}, 64'd3);
    step();
    chk("lat_t3_v", {63'd0, log_v}, 64'd0);

    // valid without ready is not an event
    ar_v = 1; ar_r = 0;
    aw_v = 0; aw_r = 1;
    step();
    idle();
    step();
    step();
    chk("no_hs", {63'd0, log_v}, 64'd0);

    // one pair after reset
    do_reset();
`ifdef AXI_LOG_ARB_AW_PRIO_EN
    set_aw(8'h02, 32'hB0, 8'd1, 1);
    set_ar(8'h01, 32'hA0, 8'd0, 1);
`else
    set_ar(8'h01, 32'hA0, 8'd0, 1);
    set_aw(8'h02, 32'hB0, 8'd1, 1);
`endif
    step();
    idle();
    step();
`ifdef AXI_LOG_ARB_AW_PRIO_EN
    chk("pair_first", {55'd0, log_id}, 64'h102);
    step();
    chk("pair_second", {55'd0, log_id}, 64'h001);
`else
    chk("pair_first", {55'd0, log_id}, 64'h001);
    step();
    chk("pair_second", {55'd0, log_id}, 64'h102);
`endif
    drain(4);

    // four cycles of paired traffic
    do_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef AXI_LOG_ARB_AW_PRIO_EN
      set_ar(8'(8'h10 + i), 32'(32'hA00 + i), 8'(i), 0);
      set_aw(8'(8'h20 + i), 32'(32'hB00 + i), 8'(i), 1);
`else
      set_ar(8'(8'h10 + i), 32'(32'hA00 + i), 8'(i), 1);
      set_aw(8'(8'h20 + i), 32'(32'hB00 + i), 8'(i), 1);
`endif
      step();
    end
`ifdef AXI_LOG_ARB_AW_PRIO_EN
    for (int i = 0; i < 4; i++)
      exp_q.push_back({1'b0, 8'(8'h10 + i),
                       32'(32'hA00 + i), 8'(i)});
`endif
    idle();
    drain(12);
    chk("pairs_ardrop", 64'(ar_cnt), 64'd0);
    chk("pairs_awdrop", 64'(aw_cnt), 64'd0);

    // logger full from reset: 6 AR events, one dropped
    do_reset();
    full = 1;
    for (int i = 0; i < 6; i++) begin
      set_ar(8'(8'h30 + i), 32'(32'h2000 + 4 * i), 8'(i), i < 5);
      step();
    end
    idle();
    step();
    chk("full_held_v", {63'd0, log_v}, 64'd1);
    chk("full_held_id", {55'd0, log_id}, 64'h030);
    chk("full_drop", 64'(ar_cnt), 64'd1);
    full = 0;
    repeat (5) step();
    chk("full_burst", 64'(exp_q.size()), 64'd0);
    chk("full_done_v", {63'd0, log_v}, 64'd0);

    // clear with buffered events and nonzero drop count
    do_reset();
    full = 1;
    for (int i = 0; i < 7; i++) begin
      set_ar(8'(8'h40 + i), 32'(32'h3000 + i), 8'(i), 0);
      step();
    end
    idle();
    chk("clr_pre_drop", 64'(ar_cnt), 64'd2);
    clr = 1;
    set_ar(8'h4F, 32'h30FF, 8'd9, 0);
    step();
    clr = 0;
    idle();
    chk("clr_valid", {63'd0, log_v}, 64'd0);
    chk("clr_ardrop", 64'(ar_cnt), 64'd0);
    chk("clr_awdrop", 64'(aw_cnt), 64'd0);
    full = 0;
    repeat (6) step();
    chk("clr_quiet", {63'd0, log_v}, 64'd0);

    // AW drop counter saturates
    do_reset();
    full = 1;
    for (int i = 0; i < 10; i++) begin
      set_aw(8'(8'h50 + i), 32'(32'h4000 + i), 8'(i), 0);
      step();
    end
    idle();
    chk("sat_awdrop", 64'(aw_cnt), 64'd3);
    chk("sat_ardrop", 64'(ar_cnt), 64'd0);
    chk("sat_held_id", {55'd0, log_id}, 64'h150);
    clr = 1;
    step();
    clr = 0;
    chk("sat_clr", 64'(aw_cnt), 64'd0);
    full = 0;
    repeat (3) step();

    // asynchronous reset mid-operation
    full = 1;
    for (int i = 0; i < 7; i++) begin
      set_ar(8'(8'h60 + i), 32'(32'h5000 + i), 8'(i), 0);
      step();
    end
    idle();
    #2;
    rst = 1;
    #1;
    chk("arst_valid", {63'd0, log_v}, 64'd0);
    chk("arst_drop", 64'(ar_cnt), 64'd0);
    step();
    rst = 0;
    full = 0;
    repeat (6) step();
    chk("arst_quiet", {63'd0, log_v}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
